// File: rtl/bit_deserialize.sv
// Slice-wise shift deserializer: collects N = DATA_WIDTH/SLICE_WIDTH slices per word
// after a sync marker and emits each completed word with a one-cycle valid strobe.
module bit_deserialize #(
  parameter string BLOCK_NAME      = "bit_deserialize",
  parameter int    X               = 0,
  parameter int    Y               = 0,
  parameter int    DX              = 0,
  parameter int    DY              = 0,
  parameter string ARCHITECTURE    = "BEHAVIORAL",
  parameter int    DATA_WIDTH      = 8,
  parameter int    SLICE_WIDTH     = 1,
  parameter int    SHIFT_DIRECTION = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync,
  input  logic [SLICE_WIDTH-1:0] slice_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  output logic                   sync_err
);

  localparam int N     = DATA_WIDTH / SLICE_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {WAIT_SYNC, COLLECT} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic                    err_reg, err_next;

  // shifted: accumulator with slice_in shifted in; loaded: same shift applied to an empty word
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   loaded;

  // Every architecture currently maps onto the same behavioral datapath.
  if (ARCHITECTURE != "BEHAVIORAL" && ARCHITECTURE != "VIRTEX5" && ARCHITECTURE != "VIRTEX6"
      || BLOCK_NAME == "" || X < 0 || Y < 0 || DX < 0 || DY < 0) begin : g_unsupported_cfg
  end

  if (N == 1) begin : g_full_slice
    assign shifted = slice_in;
    assign loaded  = slice_in;
  end else if (SHIFT_DIRECTION != 0) begin : g_right
    assign shifted = {slice_in, acc_reg[DATA_WIDTH-1:SLICE_WIDTH]};
    assign loaded  = {slice_in, {(DATA_WIDTH-SLICE_WIDTH){1'b0}}};
  end else begin : g_left
    assign shifted = {acc_reg[DATA_WIDTH-SLICE_WIDTH-1:0], slice_in};
    assign loaded  = {{(DATA_WIDTH-SLICE_WIDTH){1'b0}}, slice_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WAIT_SYNC;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (en) begin
      if (sync) begin
        // A restart always wins, even over a word that would otherwise complete now.
        state_next = COLLECT;
        acc_next   = loaded;
        err_next   = (state_reg == COLLECT) && (cnt_reg != '0);
        if (N == 1) begin
          data_next  = loaded;
          valid_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = CNT_ONE;
        end
      end else if (state_reg == COLLECT) begin
        acc_next = shifted;
        if (cnt_reg == CNT_LAST) begin
          data_next  = shifted;
          valid_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign data_out  = data_reg;
  assign valid_out = valid_reg;
  assign sync_err  = err_reg;

endmodule

// File: tb/tb_bit_deserialize.sv
// Bench for bit_deserialize: one right-shift and one left-shift instance (8-bit words,
// 2-bit slices) on shared stimulus, with per-instance expected-word queues.
module tb_bit_deserialize;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] slice_in = 2'b00;
  logic [7:0] data_r, data_l;
  logic       valid_r, valid_l, err_r, err_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] q_r[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  bit_deserialize #(.DATA_WIDTH(8), .SLICE_WIDTH(2), .SHIFT_DIRECTION(1)) dut_r (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .slice_in(slice_in),
    .data_out(data_r), .valid_out(valid_r), .sync_err(err_r)
  );

  bit_deserialize #(.DATA_WIDTH(8), .SLICE_WIDTH(2), .SHIFT_DIRECTION(0)) dut_l (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .slice_in(slice_in),
    .data_out(data_l), .valid_out(valid_l), .sync_err(err_l)
  );

  // Scoreboard: every valid strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (valid_r === 1'b1) begin
      checks++;
      if (q_r.size() == 0) begin
        errors++;
        $display("FAIL word_r: unexpected word %h, none expected", data_r);
      end else begin
        logic [7:0] exp_w;
        exp_w = q_r.pop_front();
        if (data_r !== exp_w) begin
          errors++;
          $display("FAIL word_r: got %h expected %h", data_r, exp_w);
        end else $display("word_r %h ok", data_r);
      end
    end
    if (valid_l === 1'b1) begin
      checks++;
      if (q_l.size() == 0) begin
        errors++;
        $display("FAIL word_l: unexpected word %h, none expected", data_l);
      end else begin
        logic [7:0] exp_w;
        exp_w = q_l.pop_front();
        if (data_l !== exp_w) begin
          errors++;
          $display("FAIL word_l: got %h expected %h", data_l, exp_w);
        end else $display("word_l %h ok", data_l);
      end
    end
  end

  task automatic step(input logic e, input logic s, input logic [1:0] d);
    en = e;
    sync = s;
    slice_in = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    checks += 6;
    if (data_r !== 8'h00) begin errors++; $display("FAIL reset_data_r: got %h expected 00", data_r); end
    if (data_l !== 8'h00) begin errors++; $display("FAIL reset_data_l: got %h expected 00", data_l); end
    if (valid_r !== 1'b0) begin errors++; $display("FAIL reset_valid_r: got %b expected 0", valid_r); end
    if (valid_l !== 1'b0) begin errors++; $display("FAIL reset_valid_l: got %b expected 0", valid_l); end
    if (err_r !== 1'b0) begin errors++; $display("FAIL reset_err_r: got %b expected 0", err_r); end
    if (err_l !== 1'b0) begin errors++; $display("FAIL reset_err_l: got %b expected 0", err_l); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    apply_reset();
    q_r.push_back(8'hE4);
    q_l.push_back(8'h1B);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k == 0, 2'(k));
      checks += 3;
      if (valid_r !== (k == 3)) begin errors++; $display("FAIL basic_valid_r k=%0d: got %b expected %b", k, valid_r, k == 3); end
      if (valid_l !== (k == 3)) begin errors++; $display("FAIL basic_valid_l k=%0d: got %b expected %b", k, valid_l, k == 3); end
      if (err_r !== 1'b0) begin errors++; $display("FAIL basic_err k=%0d: got %b expected 0", k, err_r); end
    end
    step(1'b0, 1'b0, 2'b00);
    checks += 3;
    if (valid_r !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: valid got %b expected 0", valid_r); end
    if (data_r !== 8'hE4) begin errors++; $display("FAIL basic_hold_r: got %h expected e4", data_r); end
    if (data_l !== 8'h1B) begin errors++; $display("FAIL basic_hold_l: got %h expected 1b", data_l); end
    $display("test_basic done");
  endtask

  task automatic test_gaps();
    apply_reset();
    q_r.push_back(8'hE4);
    q_l.push_back(8'h1B);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k == 0, 2'(k));
      checks += 2;
      if (valid_r !== (k == 3)) begin errors++; $display("FAIL gaps_valid_r k=%0d: got %b expected %b", k, valid_r, k == 3); end
      if (valid_l !== (k == 3)) begin errors++; $display("FAIL gaps_valid_l k=%0d: got %b expected %b", k, valid_l, k == 3); end
      for (int g = 0; g < 2; g++) begin
        // sync raised while en is low must be ignored
        step(1'b0, 1'b1, 2'b11);
        checks += 2;
        if (valid_r !== 1'b0) begin errors++; $display("FAIL gaps_idle_valid k=%0d: got %b expected 0", k, valid_r); end
        if (err_r !== 1'b0) begin errors++; $display("FAIL gaps_idle_err k=%0d: got %b expected 0", k, err_r); end
      end
    end
    $display("test_gaps done");
  endtask

  task automatic test_no_sync();
    int first_cyc;
    logic [1:0] sl[8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3};
    apply_reset();
    first_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 2'b11);
      checks++;
      if (valid_r !== 1'b0) begin errors++; $display("FAIL nosync_ignored k=%0d: valid got %b expected 0", k, valid_r); end
    end
    q_r.push_back(8'h39); q_l.push_back(8'h6C);
    q_r.push_back(8'hD2); q_l.push_back(8'h87);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 0, sl[k]);
      checks += 2;
      if (valid_r !== (k % 4 == 3)) begin errors++; $display("FAIL nosync_valid k=%0d: got %b expected %b", k, valid_r, k % 4 == 3); end
      if (err_r !== 1'b0) begin errors++; $display("FAIL nosync_err k=%0d: got %b expected 0", k, err_r); end
      if (valid_r === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        else begin
          checks++;
          if (cyc - first_cyc != 4) begin errors++; $display("FAIL nosync_spacing: got %0d cycles expected 4", cyc - first_cyc); end
        end
      end
    end
    $display("test_no_sync done");
  endtask

  task automatic test_sync_err();
    logic [1:0] sl[7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
    apply_reset();
    q_r.push_back(8'h93);
    q_l.push_back(8'hC6);
    for (int k = 0; k < 7; k++) begin
      // sync at k=3 lands on the slot that would have completed the partial word
      step(1'b1, k == 0 || k == 3, sl[k]);
      checks += 4;
      if (err_r !== (k == 3)) begin errors++; $display("FAIL syncerr_err_r k=%0d: got %b expected %b", k, err_r, k == 3); end
      if (err_l !== (k == 3)) begin errors++; $display("FAIL syncerr_err_l k=%0d: got %b expected %b", k, err_l, k == 3); end
      if (valid_r !== (k == 6)) begin errors++; $display("FAIL syncerr_valid_r k=%0d: got %b expected %b", k, valid_r, k == 6); end
      if (valid_l !== (k == 6)) begin errors++; $display("FAIL syncerr_valid_l k=%0d: got %b expected %b", k, valid_l, k == 6); end
    end
    step(1'b1, 1'b1, 2'b00);
    checks++;
    if (err_r !== 1'b0) begin errors++; $display("FAIL syncerr_aligned: got %b expected 0", err_r); end
    step(1'b1, 1'b1, 2'b01);
    checks++;
    if (err_r !== 1'b1) begin errors++; $display("FAIL syncerr_mid_restart: got %b expected 1", err_r); end
    $display("test_sync_err done");
  endtask

  task automatic test_reset_mid();
    logic [1:0] sl[4] = '{2'd2, 2'd2, 2'd1, 2'd1};
    apply_reset();
    q_r.push_back(8'hE4);
    q_l.push_back(8'h1B);
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 2'(k));
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b0, 2'b11);
    rst = 1'b1;
    step(1'b1, 1'b0, 2'b11);
    rst = 1'b0;
    checks += 3;
    if (data_r !== 8'h00) begin errors++; $display("FAIL rstmid_data_r: got %h expected 00", data_r); end
    if (data_l !== 8'h00) begin errors++; $display("FAIL rstmid_data_l: got %h expected 00", data_l); end
    if (valid_r !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid_r); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 2'b11);
      checks++;
      if (valid_r !== 1'b0) begin errors++; $display("FAIL rstmid_ignored k=%0d: got %b expected 0", k, valid_r); end
    end
    q_r.push_back(8'h5A);
    q_l.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k == 0, sl[k]);
      checks += 2;
      if (valid_r !== (k == 3)) begin errors++; $display("FAIL rstmid_valid_r k=%0d: got %b expected %b", k, valid_r, k == 3); end
      if (valid_l !== (k == 3)) begin errors++; $display("FAIL rstmid_valid_l k=%0d: got %b expected %b", k, valid_l, k == 3); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] sl[4];
    int last_cyc;
    apply_reset();
    last_cyc = -1;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) sl[k] = 2'($urandom_range(0, 3));
      q_r.push_back({sl[3], sl[2], sl[1], sl[0]});
      q_l.push_back({sl[0], sl[1], sl[2], sl[3]});
      for (int k = 0; k < 4; k++) begin
        step(1'b1, w == 0 && k == 0, sl[k]);
        checks += 2;
        if (valid_r !== (k == 3)) begin errors++; $display("FAIL b2b_valid w=%0d k=%0d: got %b expected %b", w, k, valid_r, k == 3); end
        if (err_r !== 1'b0) begin errors++; $display("FAIL b2b_err w=%0d k=%0d: got %b expected 0", w, k, err_r); end
        if (valid_r === 1'b1) begin
          if (last_cyc >= 0) begin
            checks++;
            if (cyc - last_cyc != 4) begin errors++; $display("FAIL b2b_spacing w=%0d: got %0d expected 4", w, cyc - last_cyc); end
          end
          last_cyc = cyc;
        end
      end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_no_sync();
    test_sync_err();
    test_reset_mid();
    test_back_to_back();
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    checks += 2;
    if (q_r.size() != 0) begin errors++; $display("FAIL drain_r: %0d words pending, expected 0", q_r.size()); end
    if (q_l.size() != 0) begin errors++; $display("FAIL drain_l: %0d words pending, expected 0", q_l.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
